// File: rtl/serial_load_pkg.sv
// serial_load_pkg
//   Shared definitions for serial_load_ctrl and its bit counter:
//   - FSM state encodings (S_IDLE, S_SHIFT, S_CHK, S_LOAD)
//   - default word width
//   - even_parity(): the parity bit that makes the word plus parity even.
package serial_load_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_CHK   = 2'd2;
  localparam logic [1:0] S_LOAD  = 2'd3;

  // Words narrower than 32 bits are zero-extended by the caller, which
  // leaves the XOR unchanged.
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/serial_load_ctrl_bit_counter.sv
// bit_counter
//   Counts the data bits of one frame, from 0 to WIDTH-1. The count returns
//   to 0 after the terminal value, so it never exceeds WIDTH-1.
//   Ports:
//     clk  in   rising-edge clock
//     clr  in   synchronous clear; takes priority over en
//     en   in   advance the count by one
//     tc   out  terminal count, high while cnt == WIDTH-1
module bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == LAST);

endmodule

// File: rtl/serial_load_ctrl.sv
// serial_load_ctrl
//   Feeder for an enable-D flip-flop register bank. The block waits for a
//   start pulse, deserialises WIDTH bits of sin (LSB first), then presents
//   the word on d with a one-cycle en strobe. The bank therefore captures
//   each word exactly once, and it holds its value between strobes.
//
//   Build option: define SERIAL_LOAD_PARITY_EN to expect one even-parity bit
//   after the data bits. On a parity mismatch, err pulses instead of en and
//   d is left unchanged. Without the macro there is no CHK state and err is
//   tied to 0.
//
//   Protocol: start is sampled only in IDLE. It is neither queued nor acted
//   on while busy. en is a single-cycle strobe with no back-pressure, and d
//   is valid whenever en is high.
//
//   Ports:
//     clk        in   rising-edge clock
//     reset      in   synchronous, active-high reset; aborts any frame
//     start      in   frame start
//     sin        in   serial data, one bit per clock after start
//     d          out  assembled word (registered)
//     en         out  one-cycle load strobe (registered)
//     busy       out  high in every non-IDLE state
//     err        out  parity error pulse
//     dbg_state  out  current FSM state, for observation only
module serial_load_ctrl
  import serial_load_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sin,
  output logic [WIDTH-1:0] d,
  output logic             en,
  output logic             busy,
  output logic             err,
  output logic [1:0]       dbg_state
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             en_q, en_d;
  logic [WIDTH-1:0] sr_shifted;
  logic             cnt_clr, cnt_en, cnt_tc;
`ifdef SERIAL_LOAD_PARITY_EN
  logic             err_q, err_d;
`endif

  // The first bit ends up at bit 0 after WIDTH shifts.
  assign sr_shifted = {sin, sr_q[WIDTH-1:1]};

  // The counter idles at 0 outside SHIFT, so every frame counts from 0.
  assign cnt_clr = reset || (state_q != S_SHIFT);
  assign cnt_en  = (state_q == S_SHIFT);

  bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk (clk),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    d_d     = d_q;
    en_d    = 1'b0;
`ifdef SERIAL_LOAD_PARITY_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sr_d = sr_shifted;
        if (cnt_tc) begin
`ifdef SERIAL_LOAD_PARITY_EN
          state_d = S_CHK;
`else
          // en and d are registered together, so both change on the edge
          // that enters LOAD.
          state_d = S_LOAD;
          en_d    = 1'b1;
          d_d     = sr_shifted;
`endif
        end
      end
`ifdef SERIAL_LOAD_PARITY_EN
      S_CHK: begin
        // LOAD is entered either way. On a mismatch it carries err instead
        // of en, so busy stays high through it.
        state_d = S_LOAD;
        if (sin == even_parity(32'(sr_q))) begin
          en_d = 1'b1;
          d_d  = sr_q;
        end else begin
          err_d = 1'b1;
        end
      end
`endif
      S_LOAD: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      d_q     <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      d_q     <= d_d;
      en_q    <= en_d;
    end
  end

`ifdef SERIAL_LOAD_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign d         = d_q;
  assign en        = en_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_load_ctrl.sv
// tb_serial_load_ctrl
//   Drives directed and random frames into serial_load_ctrl. The DUT is
//   compared every cycle against a frame-level model that counts clock edges
//   since start and predicts d/en/busy/err. Every predicted load is also
//   pushed to exp_q and matched against the word shown with en.
module tb_serial_load_ctrl;

  localparam int W = 8;
`ifdef SERIAL_LOAD_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         sin   = 1'b0;
  logic [W-1:0] d;
  logic         en;
  logic         busy;
  logic         err;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  serial_load_ctrl #(
    .WIDTH (W),
    .CNT_W (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sin       (sin),
    .d         (d),
    .en        (en),
    .busy      (busy),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always begin
    #7 clk = 1'b1;
    #8 clk = 1'b0;
  end

  // ---------------- helpers ----------------
  function automatic logic parity_of(input logic [W-1:0] w);
    int ones = 0;
    for (int i = 0; i < W; i++) if (w[i]) ones++;
    return logic'(ones % 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is the start edge, W data edges, P parity edges and one load
  // edge. The position within the frame decides every output.
  bit           m_in_frame = 1'b0;
  int           m_pos      = 0;
  logic [W-1:0] m_word     = '0;
  logic [W-1:0] m_d        = '0;
  bit           m_en       = 1'b0;
  bit           m_err      = 1'b0;
  int           cyc        = 0;
  logic [W-1:0] exp_q[$];
  int           en_cyc[$];

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_in_frame = 1'b0;
      m_pos      = 0;
      m_d        = '0;
      m_en       = 1'b0;
      m_err      = 1'b0;
    end else if (!m_in_frame) begin
      m_en  = 1'b0;
      m_err = 1'b0;
      if (start) begin
        m_in_frame = 1'b1;
        m_pos      = 0;
        m_word     = '0;
      end
    end else begin
      m_pos++;
      if (m_pos <= W) m_word[m_pos-1] = sin;
      if (m_pos == W + P) begin
        if (P == 0 || sin == parity_of(m_word)) begin
          m_en = 1'b1;
          m_d  = m_word;
          exp_q.push_back(m_word);
        end else begin
          m_err = 1'b1;
        end
      end else if (m_pos == W + P + 1) begin
        m_in_frame = 1'b0;
        m_en       = 1'b0;
        m_err      = 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  bit cmp_on = 1'b0;

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("d", d, m_d);
      chk("en", en, m_en);
      chk("busy", busy, m_in_frame);
      chk("err", err, m_err);
      if (en === 1'b1) begin
        en_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL load_word: got en with d=%0h, expected no load", d);
        end else begin
          chk("load_word", d, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  // smask[i] is the start value driven while data bit i is presented.
  // rst_at pulses reset on the edge that samples bit rst_at (-1: never).
  task automatic send_frame(input logic [W-1:0] w, input logic par,
                            input logic [W-1:0] smask, input int rst_at);
    @(negedge clk);
    start = 1'b1;
    sin   = logic'($urandom_range(0, 1));
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      start = smask[i];
      sin   = w[i];
      reset = (i == rst_at);
    end
    if (P == 1) begin
      @(negedge clk);
      sin   = par;
      reset = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] w;
    logic [W-1:0] m;
    logic         p;
    int           r;

    // Test 1: reset state, then sin activity with start low
    reset = 1'b1;
    @(negedge clk);
    cmp_on = 1'b1;
    @(negedge clk);
    chk("rst_d", d, 8'h00);
    chk("rst_en", en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_state", dbg_state, 0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sin = ~sin;
    end
    @(negedge clk);
    chk("idle_d", d, 8'h00);
    chk("idle_busy", busy, 0);

    // Test 2: single frame 8'hA5
    en_cyc.delete();
    send_frame(8'hA5, parity_of(8'hA5), 8'h00, -1);
    @(negedge clk);
    chk("a5_en", en, 1);
    chk("a5_d", d, 8'hA5);
    @(negedge clk);
    chk("a5_en_fall", en, 0);
    chk("a5_busy_fall", busy, 0);
    chk("a5_pulses", en_cyc.size(), 1);

    // Test 3: back-to-back 8'h3C, 8'hFF with start held high
    en_cyc.delete();
    send_frame(8'h3C, parity_of(8'h3C), 8'hFF, -1);
    @(negedge clk);
    chk("b2b_first_d", d, 8'h3C);
    chk("b2b_first_en", en, 1);
    send_frame(8'hFF, parity_of(8'hFF), 8'h00, -1);
    @(negedge clk);
    chk("b2b_second_d", d, 8'hFF);
    @(negedge clk);
    chk("b2b_pulses", en_cyc.size(), 2);
    if (en_cyc.size() == 2) chk("b2b_gap", en_cyc[1] - en_cyc[0], 10 + P);

    // Test 4: reset during bit 5 of 8'h81, then 8'h0F
    en_cyc.delete();
    send_frame(8'h81, parity_of(8'h81), 8'h00, 5);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_d", d, 8'h00);
    chk("abort_pulses", en_cyc.size(), 0);
    send_frame(8'h0F, parity_of(8'h0F), 8'h00, -1);
    @(negedge clk);
    chk("after_abort_d", d, 8'h0F);
    chk("after_abort_en", en, 1);
    @(negedge clk);

    // Test 5: start pulses inside frame 8'h55 are ignored
    en_cyc.delete();
    send_frame(8'h55, parity_of(8'h55), 8'b0100_0100, -1);
    @(negedge clk);
    chk("ign_d", d, 8'h55);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("ign_pulses", en_cyc.size(), 1);

`ifdef SERIAL_LOAD_PARITY_EN
    // Test 6: parity accepted, then rejected
    en_cyc.delete();
    send_frame(8'hA5, 1'b0, 8'h00, -1);
    @(negedge clk);
    chk("par_ok_en", en, 1);
    chk("par_ok_d", d, 8'hA5);
    chk("par_ok_err", err, 0);
    @(negedge clk);
    send_frame(8'h01, 1'b0, 8'h00, -1);
    @(negedge clk);
    chk("par_bad_err", err, 1);
    chk("par_bad_en", en, 0);
    chk("par_bad_d", d, 8'hA5);
    @(negedge clk);
    chk("par_bad_err_fall", err, 0);
    chk("par_pulses", en_cyc.size(), 1);
`endif

    // Random frames: data, stray starts, bad parity, mid-frame resets
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 3);
      for (int g = 0; g < r; g++) begin
        @(negedge clk);
        start = 1'b0;
        sin   = logic'($urandom_range(0, 1));
      end
      w = W'($urandom);
      m = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      p = parity_of(w) ^ ($urandom_range(0, 3) == 0);
      send_frame(w, p, m, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, W - 1)) : -1);
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
    end

    // Drain any frame a stray start began, then confirm nothing is pending
    start = 1'b0;
    reset = 1'b0;
    repeat (W + P + 4) @(negedge clk);
    chk("scoreboard_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
